// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
//   A multiply or divide takes WIDTH iterations plus one sign fix-up cycle.
//   HI/LO are written only when an operation completes.
//
//   Optional feature macro: HILO_DIV_EN
//     defined   -> DIVU/DIV are implemented (restoring divider).
//     undefined -> divide ops are accepted but rejected with a one-cycle err pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active high
//   start     operation request, accepted only in IDLE
//   op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b      rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hl_sel    0 selects LO, 1 selects HI on hilo_out
//   busy      high while an operation is in flight
//   done      one-cycle pulse after HI/LO are updated
//   err       one-cycle pulse when a divide op is rejected
//   hi, lo    HI and LO registers
//   hilo_out  combinational HI/LO select
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hl_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] opnd_q;    // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi_q;  // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_q;  // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_q;     // negate product or quotient at fix-up
  logic             busy_q;
  logic             done_q;
`ifdef HILO_DIV_EN
  logic             is_div_q;
  logic             rem_neg_q; // remainder takes the dividend's sign
`else
  logic             err_q;
`endif

  // Operand sign strip; only the signed ops (op[0]=1) look at sign bits.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Shift-add multiply step; the carry out of the add lands in HI's MSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_res;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_prod = {acc_hi_q, acc_lo_q};
    mul_res  = neg_q ? -mul_prod : mul_prod;
  end

`ifdef HILO_DIV_EN
  // Restoring divide step. With a zero divisor every step "fits", so the
  // quotient becomes all ones and the remainder collects |a|; the normal
  // remainder sign fix then reproduces a as latched.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_hi_d;
  logic [WIDTH-1:0] div_lo_d;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  always_comb begin
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opnd_q});
    if (div_fits) begin
      div_hi_d = WIDTH'(div_shift - {1'b0, opnd_q});
      div_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_d = WIDTH'(div_shift);
      div_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
    end
    quo_res = (opnd_q == '0) ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    rem_res = rem_neg_q ? -acc_hi_q : acc_hi_q;
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef HILO_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
`else
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifndef HILO_DIV_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
`ifdef HILO_DIV_EN
            is_div_q  <= op[1];
            rem_neg_q <= a_neg;
            if (op[1]) begin
              opnd_q   <= b_mag;
              acc_lo_q <= a_mag;
            end else begin
              opnd_q   <= a_mag;
              acc_lo_q <= b_mag;
            end
            acc_hi_q <= '0;
            neg_q    <= a_neg ^ b_neg;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
`else
            if (op[1]) begin
              err_q <= 1'b1;
            end else begin
              opnd_q   <= a_mag;
              acc_lo_q <= b_mag;
              acc_hi_q <= '0;
              neg_q    <= a_neg ^ b_neg;
              count_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end
`endif
          end
        end
        S_RUN: begin
`ifdef HILO_DIV_EN
          if (is_div_q) begin
            acc_hi_q <= div_hi_d;
            acc_lo_q <= div_lo_d;
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
`else
          acc_hi_q <= mul_sum[WIDTH:1];
          acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
`ifdef HILO_DIV_EN
          if (is_div_q) begin
            hi_q <= rem_res;
            lo_q <= quo_res;
          end else begin
            hi_q <= mul_res[2*WIDTH-1:WIDTH];
            lo_q <= mul_res[WIDTH-1:0];
          end
`else
          hi_q <= mul_res[2*WIDTH-1:WIDTH];
          lo_q <= mul_res[WIDTH-1:0];
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign hilo_out = hl_sel ? hi_q : lo_q;
`ifdef HILO_DIV_EN
  assign err      = 1'b0;
`else
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;

`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hl_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  int n_pass  = 0;
  int n_total = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hl_sel   (hl_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .hi       (hi),
    .lo       (lo),
    .hilo_out (hilo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} result of an op from the arithmetic definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] ux;
    logic [63:0] uy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00:   r = ux * uy;
      2'b01:   r = 64'(sx * sy);
      2'b10:   r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
      default: r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op, scramble the operand inputs after accept, wait for the
  // result and check timing, busy, err and the HI/LO values.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [63:0] exp;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          lat;
    int          bcnt;
    old_hi = hi;
    old_lo = lo;
    exp    = model(o, x, y);
    hl_sel = 1'b0;
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    tick();
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    if (o[1] && !DIV_EN) begin
      check({tag, " err"}, 64'(err), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      tick();
      check({tag, " err_clr"}, 64'(err), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " hilo_keep"}, {hi, lo}, {old_hi, old_lo});
    end else begin
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 60) begin
        if (busy) bcnt++;
        if (lat == 5) check({tag, " hilo_old"}, 64'(hilo_out), 64'(old_lo));
        tick();
        lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd33);
      check({tag, " busy_cycles"}, 64'(bcnt), 64'd33);
      check({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check({tag, " err"}, 64'(err), 64'd0);
      check({tag, " hilo"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    int          lat;
    logic        saw_done;
    logic [63:0] exp;

    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    hl_sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset err", 64'(err), 64'd0);

    // Directed arithmetic cases.
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    hl_sel = 1'b1;
    #1;
    check("hl_sel hi", 64'(hilo_out), 64'hFFFF_FFFF);
    hl_sel = 1'b0;
    #1;
    check("hl_sel lo", 64'(hilo_out), 64'hFFFF_FFF1);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    check("mult_minmin const", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(2'b10, 32'd5, 32'd0, "divu_by0");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");

    // Start while busy is ignored; start during done is accepted.
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (9) begin tick(); lat++; end
    start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    lat++;
    start = 1'b0;
    check("ignored start busy", 64'(busy), 64'd1);
    while (!done && lat < 60) begin tick(); lat++; end
    check("ignored start latency", 64'(lat), 64'd34);
    check("ignored start hilo", {hi, lo}, 64'd42);
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    check("b2b accept busy", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 60) begin tick(); lat++; end
    check("b2b latency", 64'(lat), 64'd33);
    check("b2b hilo", {hi, lo}, 64'd81);

    // Reset mid-operation aborts with no write and no done.
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FF00; b = 32'd77;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("midrst no done", 64'(saw_done), 64'd0);
    do_op(2'b00, 32'd2, 32'd3, "after_rst");
    exp = 64'd6;
    check("after_rst const", {hi, lo}, exp);

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
